// File: rtl/lockstep_if.sv
// Bus bundle for lockstep_checker: compare stimulus from the pipeline/model side
// and the checker's verdict, first-mismatch capture and counters.
interface lockstep_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     start;
  logic                     clr;
  logic                     stall;
  logic                     hlt;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] dut_data;
  logic [NUM_CH*DATA_W-1:0] ref_data;
  logic [NUM_CH-1:0]        mismatch_vec;
  logic [15:0]              err_cnt;
  logic [CH_W-1:0]          first_ch;
  logic [DATA_W-1:0]        first_dut;
  logic [DATA_W-1:0]        first_ref;
  logic [31:0]              first_cycle;
  logic [31:0]              cycle_cnt;
  logic [2:0]               state;
  logic                     done;

  modport master (
    output start, clr, stall, hlt, ch_valid, dut_data, ref_data,
    input  mismatch_vec, err_cnt, first_ch, first_dut, first_ref,
           first_cycle, cycle_cnt, state, done
  );

  modport slave (
    input  start, clr, stall, hlt, ch_valid, dut_data, ref_data,
    output mismatch_vec, err_cnt, first_ch, first_dut, first_ref,
           first_cycle, cycle_cnt, state, done
  );
endinterface

// File: rtl/lockstep_checker.sv
// Per-cycle DUT vs reference lockstep comparator with halt drain, run watchdog,
// first-mismatch capture and saturating error count. Option: LOCKSTEP_STOP_ON_FAIL_EN.
module lockstep_checker #(
  parameter int unsigned NUM_CH       = 5,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic       clk,
  input logic       rst_n,
  lockstep_if.slave bus
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned POP_W = $clog2(NUM_CH + 1);
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [31:0]      TOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4,
    S_TOUT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mism_c;
  logic              any_c;
  logic              stop_c;
  logic [POP_W-1:0]  pop_c;
  logic [CH_W-1:0]   first_idx_c;
  logic [DATA_W-1:0] first_dut_c, first_ref_c;
  logic [16:0]       err_sum_c;
  logic [15:0]       err_d;

  logic [NUM_CH-1:0] mismatch_q;
  logic [15:0]       err_q;
  logic              first_seen_q;
  logic [CH_W-1:0]   first_ch_q;
  logic [DATA_W-1:0] first_dut_q, first_ref_q;
  logic [31:0]       first_cycle_q;
  logic [31:0]       cycle_q;
  logic [DRN_W-1:0]  drain_q;
  logic              done_q;

  // Channel compare; ascending scan keeps the lowest mismatching index.
  always_comb begin
    mism_c      = '0;
    any_c       = 1'b0;
    pop_c       = '0;
    first_idx_c = '0;
    first_dut_c = '0;
    first_ref_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((state_q == S_RUN || state_q == S_DRAIN) && !bus.stall && bus.ch_valid[i] &&
          (bus.dut_data[i*DATA_W +: DATA_W] != bus.ref_data[i*DATA_W +: DATA_W])) begin
        mism_c[i] = 1'b1;
        pop_c     = pop_c + POP_W'(1);
        if (!any_c) begin
          first_idx_c = CH_W'(i);
          first_dut_c = bus.dut_data[i*DATA_W +: DATA_W];
          first_ref_c = bus.ref_data[i*DATA_W +: DATA_W];
        end
        any_c = 1'b1;
      end
    end
    err_sum_c = 17'(err_q) + 17'(pop_c);
    err_d     = err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef LOCKSTEP_STOP_ON_FAIL_EN
    stop_c  = any_c;
`else
    stop_c  = 1'b0;
`endif
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (stop_c)                     state_d = S_FAIL;
        else if (bus.hlt)               state_d = S_DRAIN;
        else if (cycle_q == TOUT_LAST)  state_d = S_TOUT;
      end
      S_DRAIN: begin
        if (stop_c)                     state_d = S_FAIL;
        else if (drain_q == DRN_LAST)   state_d = (err_d != 16'h0) ? S_FAIL : S_PASS;
      end
      S_PASS, S_FAIL, S_TOUT: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
    if (bus.clr) state_d = S_IDLE;
  end

  // Datapath registers: counters, capture and verdict flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q    <= '0;
      err_q         <= '0;
      first_seen_q  <= 1'b0;
      first_ch_q    <= '0;
      first_dut_q   <= '0;
      first_ref_q   <= '0;
      first_cycle_q <= '0;
      cycle_q       <= '0;
      drain_q       <= '0;
      done_q        <= 1'b0;
    end else if (bus.clr) begin
      mismatch_q    <= '0;
      err_q         <= '0;
      first_seen_q  <= 1'b0;
      first_ch_q    <= '0;
      first_dut_q   <= '0;
      first_ref_q   <= '0;
      first_cycle_q <= '0;
      cycle_q       <= '0;
      drain_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      mismatch_q <= mism_c;
      err_q      <= err_d;
      if (any_c && !first_seen_q) begin
        first_seen_q  <= 1'b1;
        first_ch_q    <= first_idx_c;
        first_dut_q   <= first_dut_c;
        first_ref_q   <= first_ref_c;
        first_cycle_q <= cycle_q;
      end
      if ((state_q == S_RUN || state_q == S_DRAIN) && (cycle_q != 32'hFFFF_FFFF))
        cycle_q <= cycle_q + 32'd1;
      drain_q <= (state_q == S_DRAIN) ? drain_q + DRN_W'(1) : '0;
      done_q  <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TOUT);
    end
  end

  assign bus.mismatch_vec = mismatch_q;
  assign bus.err_cnt      = err_q;
  assign bus.first_ch     = first_ch_q;
  assign bus.first_dut    = first_dut_q;
  assign bus.first_ref    = first_ref_q;
  assign bus.first_cycle  = first_cycle_q;
  assign bus.cycle_cnt    = cycle_q;
  assign bus.state        = state_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker; expected mismatch vectors go through a
// scoreboard queue, end-of-run values are fixed constants.
module tb_lockstep_checker;
  localparam int unsigned NUM_CH = 5;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [NUM_CH-1:0] exp_q[$];

  lockstep_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus   ();
  lockstep_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus_t ();

  lockstep_checker #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(1000000), .DRAIN_CYCLES(3))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  lockstep_checker #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(50), .DRAIN_CYCLES(3))
    u_tout (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".state"},       64'(bus.state),        64'd0);
    check({tag, ".done"},        64'(bus.done),         64'd0);
    check({tag, ".err_cnt"},     64'(bus.err_cnt),      64'd0);
    check({tag, ".cycle_cnt"},   64'(bus.cycle_cnt),    64'd0);
    check({tag, ".first_cycle"}, 64'(bus.first_cycle),  64'd0);
    check({tag, ".first_ch"},    64'(bus.first_ch),     64'd0);
    check({tag, ".first_dut"},   64'(bus.first_dut),    64'd0);
    check({tag, ".first_ref"},   64'(bus.first_ref),    64'd0);
    check({tag, ".mismatch"},    64'(bus.mismatch_vec), 64'd0);
  endtask

  // One clock of stimulus; act says whether the checker should be comparing.
  task automatic step(input bit act, input bit st, input bit stl, input bit h,
                      input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] mask);
    bus.start    = st;
    bus.stall    = stl;
    bus.hlt      = h;
    bus.ch_valid = v;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      logic [DATA_W-1:0] w;
      w = (i == 3) ? 16'h1234 : 16'(i * 16'h0111 + cyc);
      bus.dut_data[i*DATA_W +: DATA_W] = w;
      bus.ref_data[i*DATA_W +: DATA_W] = mask[i] ? (w ^ 16'h0001) : w;
    end
    exp_q.push_back((act && !stl) ? (v & mask) : '0);
    @(posedge clk); #1;
    cyc++;
    check("mismatch_vec", 64'(bus.mismatch_vec), 64'(exp_q.pop_front()));
    bus.start = 1'b0;
    bus.hlt   = 1'b0;
  endtask

  task automatic do_clr(input string tag);
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 0; bus.clr = 0; bus.stall = 0; bus.hlt = 0;
    bus.ch_valid = '0; bus.dut_data = '0; bus.ref_data = '0;
    bus_t.start = 0; bus_t.clr = 0; bus_t.stall = 0; bus_t.hlt = 0;
    bus_t.ch_valid = '0; bus_t.dut_data = '0; bus_t.ref_data = '0;
    repeat (2) @(posedge clk); #1;
    check_idle("reset");
    check("tout.reset_state", 64'(bus_t.state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean run: 20 RUN cycles (hlt on the 20th), 3 DRAIN, PASS.
    step(0, 1, 0, 0, '1, '0);
    check("t1.run_state", 64'(bus.state), 64'd1);
    check("t1.cycle0", 64'(bus.cycle_cnt), 64'd0);
    repeat (19) step(1, 0, 0, 0, '1, '0);
    step(1, 0, 0, 1, '1, '0);
    check("t1.drain_state", 64'(bus.state), 64'd2);
    repeat (3) step(1, 0, 0, 0, '1, '0);
    check("t1.pass_state", 64'(bus.state), 64'd3);
    check("t1.done", 64'(bus.done), 64'd1);
    check("t1.err", 64'(bus.err_cnt), 64'd0);
    check("t1.cycle_cnt", 64'(bus.cycle_cnt), 64'd23);
    step(0, 1, 0, 1, '1, '1);
    check("t1.terminal_hold", 64'(bus.state), 64'd3);
    do_clr("t1.clr");

    // First-mismatch capture: ch3 at cycle 7, ch1+ch3 at cycle 9.
    step(0, 1, 0, 0, '1, '0);
    repeat (7) step(1, 0, 0, 0, '1, '0);
    step(1, 0, 0, 0, '1, 5'b01000);
    check("t2.err1", 64'(bus.err_cnt), 64'd1);
    check("t2.first_ch", 64'(bus.first_ch), 64'd3);
    check("t2.first_dut", 64'(bus.first_dut), 64'h1234);
    check("t2.first_ref", 64'(bus.first_ref), 64'h1235);
    check("t2.first_cycle", 64'(bus.first_cycle), 64'd7);
`ifdef LOCKSTEP_STOP_ON_FAIL_EN
    check("t2.stop_state", 64'(bus.state), 64'd4);
    check("t2.stop_done", 64'(bus.done), 64'd1);
    step(0, 0, 0, 1, '1, 5'b01010);
    check("t2.stop_err_hold", 64'(bus.err_cnt), 64'd1);
    check("t2.stop_state_hold", 64'(bus.state), 64'd4);
`else
    check("t2.still_run", 64'(bus.state), 64'd1);
    step(1, 0, 0, 0, '1, '0);
    step(1, 0, 0, 0, '1, 5'b01010);
    check("t2.err3", 64'(bus.err_cnt), 64'd3);
    check("t2.first_ch_kept", 64'(bus.first_ch), 64'd3);
    check("t2.first_cycle_kept", 64'(bus.first_cycle), 64'd7);
    step(1, 0, 0, 1, '1, '0);
    repeat (3) step(1, 0, 0, 0, '1, '0);
    check("t2.fail_state", 64'(bus.state), 64'd4);
    check("t2.fail_done", 64'(bus.done), 64'd1);
    check("t2.fail_err", 64'(bus.err_cnt), 64'd3);
`endif
    do_clr("t2.clr_in_fail");

    // Masked comparisons: stall or ch_valid=0 hide every difference.
    step(0, 1, 0, 0, '1, '0);
    step(1, 0, 1, 0, '1, '1);
    step(1, 0, 0, 0, '0, '1);
    step(1, 0, 1, 0, '0, '1);
    step(1, 0, 0, 0, 5'b00100, 5'b11011);
    check("t3.err", 64'(bus.err_cnt), 64'd0);
    step(1, 0, 1, 1, '1, '1);
    repeat (3) step(1, 0, 1, 0, '1, '1);
    check("t3.pass_state", 64'(bus.state), 64'd3);
    check("t3.err_final", 64'(bus.err_cnt), 64'd0);
    do_clr("t3.clr");

    // Mismatch only in the final DRAIN cycle still yields FAIL.
    step(0, 1, 0, 0, '1, '0);
    step(1, 0, 0, 0, '1, '0);
    step(1, 0, 0, 1, '1, '0);
    step(1, 0, 0, 0, '1, '0);
    step(1, 0, 0, 0, '1, '0);
    check("t4.last_drain_state", 64'(bus.state), 64'd2);
    step(1, 0, 0, 0, '1, 5'b00001);
    check("t4.fail_state", 64'(bus.state), 64'd4);
    check("t4.err", 64'(bus.err_cnt), 64'd1);
    check("t4.first_ch", 64'(bus.first_ch), 64'd0);
    check("t4.first_cycle", 64'(bus.first_cycle), 64'd4);
    do_clr("t4.clr");

    // Asynchronous reset mid-DRAIN, then a clean rerun.
    step(0, 1, 0, 0, '1, '0);
    step(1, 0, 0, 0, '1, '0);
    step(1, 0, 0, 1, '1, '0);
    step(1, 0, 0, 0, '1, '0);
    check("t5.in_drain", 64'(bus.state), 64'd2);
    #2 rst_n = 1'b0;
    #1 check_idle("t5.async_rst");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 1, 0, 0, '1, '0);
    step(1, 0, 0, 1, '1, '0);
    repeat (3) step(1, 0, 0, 0, '1, '0);
    check("t5.rerun_state", 64'(bus.state), 64'd3);
    check("t5.rerun_cycles", 64'(bus.cycle_cnt), 64'd4);
    do_clr("t5.clr");

    // Watchdog instance, TIMEOUT=50.
    bus_t.start = 1'b1;
    @(posedge clk); #1;
    bus_t.start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("t6.run_at_49", 64'(bus_t.state), 64'd1);
    check("t6.cycle_49", 64'(bus_t.cycle_cnt), 64'd49);
    @(posedge clk); #1;
    check("t6.tout_state", 64'(bus_t.state), 64'd5);
    check("t6.tout_done", 64'(bus_t.done), 64'd1);
    bus_t.clr = 1'b1;
    @(posedge clk); #1;
    bus_t.clr = 1'b0;
    check("t6.clr_state", 64'(bus_t.state), 64'd0);
    bus_t.start = 1'b1;
    @(posedge clk); #1;
    bus_t.start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    bus_t.hlt = 1'b1;
    @(posedge clk); #1;
    bus_t.hlt = 1'b0;
    check("t6.hlt_wins", 64'(bus_t.state), 64'd2);

`ifndef LOCKSTEP_STOP_ON_FAIL_EN
    // Saturation: 5 mismatches/cycle, then hlt coinciding with mismatches.
    step(0, 1, 0, 0, '1, '0);
    repeat (13106) step(1, 0, 0, 0, '1, '1);
    check("t7.err_65530", 64'(bus.err_cnt), 64'd65530);
    step(1, 0, 0, 1, '1, 5'b00111);
    check("t7.hlt_mismatch_counted", 64'(bus.err_cnt), 64'd65533);
    check("t7.hlt_to_drain", 64'(bus.state), 64'd2);
    step(1, 0, 0, 0, '1, '1);
    check("t7.saturate", 64'(bus.err_cnt), 64'hFFFF);
    repeat (2) step(1, 0, 0, 0, '1, '1);
    check("t7.sat_hold", 64'(bus.err_cnt), 64'hFFFF);
    check("t7.fail_state", 64'(bus.state), 64'd4);
    do_clr("t7.clr");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
